// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, opcode/funct encodings, issue FSM states
// and the decoded-instruction payload handed from the decoder to the issue FSM.
package alu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned FIELD_W = 5;
    localparam int unsigned IMM_W   = 16;

    localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [SEL_W-1:0] ALU_SLL = 3'b100;
    localparam logic [SEL_W-1:0] ALU_SRL = 3'b101;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLL = 6'b000000;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] select;
        logic             use_imm;
        logic             imm_sext;
        logic             is_shift;
        logic             dest_is_rt;
        logic             illegal;
    } decode_t;

    // Instruction field extractors
    function automatic logic [FIELD_W-1:0] fld_rs(input logic [INSTR_W-1:0] i);
        return i[25:21];
    endfunction

    function automatic logic [FIELD_W-1:0] fld_rt(input logic [INSTR_W-1:0] i);
        return i[20:16];
    endfunction

    function automatic logic [FIELD_W-1:0] fld_rd(input logic [INSTR_W-1:0] i);
        return i[15:11];
    endfunction

    function automatic logic [SHAMT_W-1:0] fld_sh(input logic [INSTR_W-1:0] i);
        return i[10:6];
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Fetch handshake, register-file read/write and ALU drive bundle of the issue controller.
// master = issue controller, slave = surrounding fetch / register file / ALU.
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
);

    logic                             instr_valid;
    logic                             instr_ready;
    logic [alu_pkg::INSTR_W-1:0]      instr;

    logic [RADDR_W-1:0]               rs_addr;
    logic [RADDR_W-1:0]               rt_addr;
    logic [DATA_W-1:0]                rs_data;
    logic [DATA_W-1:0]                rt_data;

    logic [DATA_W-1:0]                alu_op1;
    logic [DATA_W-1:0]                alu_op2;
    logic [alu_pkg::SHAMT_W-1:0]      alu_shamt;
    logic [alu_pkg::SEL_W-1:0]        alu_select;
    logic [DATA_W-1:0]                alu_result;

    logic                             rd_we;
    logic [RADDR_W-1:0]               rd_addr;
    logic [DATA_W-1:0]                rd_wdata;
    logic                             illegal;

    modport master (
        input  instr_valid, instr, rs_data, rt_data, alu_result,
        output instr_ready, rs_addr, rt_addr,
        output alu_op1, alu_op2, alu_shamt, alu_select,
        output rd_we, rd_addr, rd_wdata, illegal
    );

    modport slave (
        output instr_valid, instr, rs_data, rt_data, alu_result,
        input  instr_ready, rs_addr, rt_addr,
        input  alu_op1, alu_op2, alu_shamt, alu_select,
        input  rd_we, rd_addr, rd_wdata, illegal
    );

endinterface

// File: rtl/alu_decode.sv
// Combinational decoder: opcode/funct to ALU select and operand/destination controls.
module alu_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output decode_t            dec
);

    always_comb begin
        dec        = '0;
        dec.select = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.select = ALU_ADD;
                    FN_SUB:  dec.select = ALU_SUB;
                    FN_AND:  dec.select = ALU_AND;
                    FN_OR:   dec.select = ALU_OR;
                    FN_SLL: begin
                        dec.select   = ALU_SLL;
                        dec.is_shift = 1'b1;
                    end
                    FN_SRL: begin
                        dec.select   = ALU_SRL;
                        dec.is_shift = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec.select     = ALU_ADD;
                dec.use_imm    = 1'b1;
                dec.imm_sext   = 1'b1;
                dec.dest_is_rt = 1'b1;
            end
            OP_ANDI: begin
                dec.select     = ALU_AND;
                dec.use_imm    = 1'b1;
                dec.dest_is_rt = 1'b1;
            end
            OP_ORI: begin
                dec.select     = ALU_OR;
                dec.use_imm    = 1'b1;
                dec.dest_is_rt = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle, non-pipelined issue controller: accept instr, read registers,
// drive the ALU for one cycle, then issue a single register-file write.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RADDR_W     = 5,
    parameter bit          R0_WRITABLE = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    alu_issue_ctrl_if.master bus
);

    state_t               state;
    state_t               state_nxt;
    logic [INSTR_W-1:0]   instr_q;
    decode_t              dec;

    logic                 load_instr;
    logic                 load_ops;
    logic                 load_wb;
    logic                 flag_illegal;

    logic                 ready_q;
    logic                 illegal_q;
    logic [DATA_W-1:0]    op1_q;
    logic [DATA_W-1:0]    op2_q;
    logic [SHAMT_W-1:0]   shamt_q;
    logic [SEL_W-1:0]     sel_q;
    logic                 rd_we_q;
    logic [RADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]    rd_wdata_q;

    logic [FIELD_W-1:0]   dest;
    logic [IMM_W-1:0]     imm;
    logic [DATA_W-1:0]    imm_ext;
    logic                 dest_writable;

    alu_decode u_decode (
        .op    (instr_q[31:26]),
        .funct (instr_q[5:0]),
        .dec   (dec)
    );

    assign imm           = instr_q[IMM_W-1:0];
    assign imm_ext       = dec.imm_sext ? DATA_W'($signed(imm)) : DATA_W'(imm);
    assign dest          = dec.dest_is_rt ? fld_rt(instr_q) : fld_rd(instr_q);
    assign dest_writable = R0_WRITABLE || (dest != '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.instr_valid) state_nxt = ST_READ;
            ST_READ: state_nxt = dec.illegal ? ST_IDLE : ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        load_instr   = 1'b0;
        load_ops     = 1'b0;
        load_wb      = 1'b0;
        flag_illegal = 1'b0;
        case (state)
            ST_IDLE: load_instr = bus.instr_valid;
            ST_READ: begin
                load_ops     = !dec.illegal;
                flag_illegal = dec.illegal;
            end
            ST_EXEC: load_wb = 1'b1;
            default: ;
        endcase
    end

    // Handshake and pulse outputs; ready tracks the upcoming state so it rises with IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b1;
            illegal_q <= 1'b0;
            rd_we_q   <= 1'b0;
        end else begin
            ready_q   <= (state_nxt == ST_IDLE);
            illegal_q <= flag_illegal;
            rd_we_q   <= load_wb && dest_writable;
        end
    end

    // Instruction latch and ALU operand registers; the ALU sees them held outside EXEC too
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            shamt_q <= '0;
            sel_q   <= ALU_ADD;
        end else begin
            if (load_instr) begin
                instr_q <= bus.instr;
            end
            if (load_ops) begin
                sel_q   <= dec.select;
                op1_q   <= dec.is_shift ? bus.rt_data : bus.rs_data;
                shamt_q <= dec.is_shift ? fld_sh(instr_q) : '0;
                if (dec.is_shift) begin
                    op2_q <= '0;
                end else if (dec.use_imm) begin
                    op2_q <= imm_ext;
                end else begin
                    op2_q <= bus.rt_data;
                end
            end
        end
    end

    // Writeback capture at the end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
        end else if (load_wb) begin
            rd_addr_q  <= RADDR_W'(dest);
            rd_wdata_q <= bus.alu_result;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.rs_addr     = RADDR_W'(fld_rs(instr_q));
    assign bus.rt_addr     = RADDR_W'(fld_rt(instr_q));
    assign bus.alu_op1     = op1_q;
    assign bus.alu_op2     = op2_q;
    assign bus.alu_shamt   = shamt_q;
    assign bus.alu_select  = sel_q;
    assign bus.rd_we       = rd_we_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.rd_wdata    = rd_wdata_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and 32x32 register file.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          acc_cnt  = 0;
    int          ill_cnt  = 0;

    logic [31:0] rf [32];
    logic        tb_we;
    logic [4:0]  tb_waddr;
    logic [31:0] tb_wdata;

    alu_issue_ctrl_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) bus ();

    alu_issue_ctrl #(
        .DATA_W      (DATA_W),
        .RADDR_W     (RADDR_W),
        .R0_WRITABLE (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: r0 reads as zero, combinational read
    assign bus.rs_data = (bus.rs_addr == 5'd0) ? 32'd0 : rf[bus.rs_addr];
    assign bus.rt_data = (bus.rt_addr == 5'd0) ? 32'd0 : rf[bus.rt_addr];

    always_comb begin
        case (bus.alu_select)
            ALU_ADD: bus.alu_result = bus.alu_op1 + bus.alu_op2;
            ALU_SUB: bus.alu_result = bus.alu_op1 - bus.alu_op2;
            ALU_AND: bus.alu_result = bus.alu_op1 & bus.alu_op2;
            ALU_OR:  bus.alu_result = bus.alu_op1 | bus.alu_op2;
            ALU_SLL: bus.alu_result = bus.alu_op1 << bus.alu_shamt;
            ALU_SRL: bus.alu_result = bus.alu_op1 >> bus.alu_shamt;
            default: bus.alu_result = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (bus.rd_we) begin
            rf[bus.rd_addr] <= bus.rd_wdata;
        end else if (tb_we) begin
            rf[tb_waddr] <= tb_wdata;
        end
        if (bus.rd_we)                       wr_cnt  <= wr_cnt + 1;
        if (bus.instr_valid && bus.instr_ready) acc_cnt <= acc_cnt + 1;
        if (bus.illegal)                     ill_cnt <= ill_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(posedge clk);
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Present w, wait (bounded) for ready, return at the negedge inside READ
    task automatic issue(input logic [31:0] w, input string tag);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 8 && bus.instr_ready !== 1'b1; k++) @(negedge clk);
        chk({tag, "_accept_ready"}, 32'(bus.instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic do_instr(input logic [31:0] w, input logic exp_we, input logic [4:0] exp_addr,
                            input logic [31:0] exp_data, input string tag);
        int w0;
        w0 = wr_cnt;
        issue(w, tag);
        chk({tag, "_ready_low"}, 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_we_exec"}, 32'(bus.rd_we), 32'd0);
        @(negedge clk);
        chk({tag, "_we_wb"}, 32'(bus.rd_we), 32'(exp_we));
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'(exp_addr));
        chk({tag, "_rd_wdata"}, bus.rd_wdata, exp_data);
        @(negedge clk);
        chk({tag, "_ready_back"}, 32'(bus.instr_ready), 32'd1);
        chk({tag, "_we_drop"}, 32'(bus.rd_we), 32'd0);
        chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_we));
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        int w0;
        int i0;
        int a0;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        tb_we           = 1'b0;
        tb_waddr        = 5'd0;
        tb_wdata        = 32'd0;
        reset           = 1'b1;

        #1;
        chk("rst_ready",   32'(bus.instr_ready), 32'd1);
        chk("rst_we",      32'(bus.rd_we),       32'd0);
        chk("rst_illegal", 32'(bus.illegal),     32'd0);
        chk("rst_op1",     bus.alu_op1,          32'd0);
        chk("rst_select",  32'(bus.alu_select),  32'd0);
        chk("rst_wdata",   bus.rd_wdata,         32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd7);
        do_instr(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 1'b1, 5'd3, 32'd12, "add");
        chk("add_rf3", rf[3], 32'd12);

        set_reg(5'd1, 32'd0);
        set_reg(5'd2, 32'd1);
        do_instr(rtype(5'd1, 5'd2, 5'd4, 5'd0, 6'b100010), 1'b1, 5'd4, 32'hFFFF_FFFF, "sub");
        do_instr(rtype(5'd0, 5'd2, 5'd5, 5'd31, 6'b000000), 1'b1, 5'd5, 32'h8000_0000, "sll");
        do_instr(itype(6'b001000, 5'd0, 5'd6, 16'hFFFF), 1'b1, 5'd6, 32'hFFFF_FFFF, "addi");
        do_instr(itype(6'b001101, 5'd0, 5'd7, 16'h8001), 1'b1, 5'd7, 32'h0000_8001, "ori");

        set_reg(5'd1, 32'hF0F0_1234);
        set_reg(5'd2, 32'h0000_00FF);
        do_instr(rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'b100100), 1'b1, 5'd12, 32'h0000_0034, "and");
        do_instr(rtype(5'd1, 5'd2, 5'd14, 5'd0, 6'b100101), 1'b1, 5'd14, 32'hF0F0_12FF, "or");
        do_instr(rtype(5'd0, 5'd1, 5'd13, 5'd4, 6'b000010), 1'b1, 5'd13, 32'h0F0F_0123, "srl");
        do_instr(itype(6'b001100, 5'd1, 5'd11, 16'hFF00), 1'b1, 5'd11, 32'h0000_1200, "andi");

        // Unsupported funct: one illegal pulse, no write, ready back after two cycles
        w0 = wr_cnt;
        i0 = ill_cnt;
        issue(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'b101010), "ill");
        chk("ill_read_pulse", 32'(bus.illegal),     32'd0);
        chk("ill_read_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        chk("ill_pulse",      32'(bus.illegal),     32'd1);
        chk("ill_ready_back", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        chk("ill_pulse_end",  32'(bus.illegal),     32'd0);
        chk("ill_count",      32'(ill_cnt - i0),    32'd1);
        chk("ill_no_write",   32'(wr_cnt - w0),     32'd0);

        do_instr(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'b100000), 1'b0, 5'd0, 32'hF0F0_1333, "add_r0");

        // Valid held high: ready (and acceptance) every 4th cycle
        a0 = acc_cnt;
        bus.instr       = rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'b100000);
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("b2b_ready_%0d", i), 32'(bus.instr_ready), 32'((i % 4) == 0));
            @(posedge clk);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
        chk("b2b_rf8",     rf[8],             32'hF0F0_1333);

        // Reset asserted during EXEC: in-flight write dropped
        w0 = wr_cnt;
        issue(rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'b100000), "rst_mid");
        @(negedge clk);
        chk("rst_mid_exec_op1", bus.alu_op1, 32'hF0F0_1234);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_mid_we",    32'(bus.rd_we),       32'd0);
        chk("rst_mid_op1",   bus.alu_op1,          32'd0);
        @(negedge clk);
        chk("rst_hold_we", 32'(bus.rd_we), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel_we",    32'(bus.rd_we),       32'd0);
        chk("rst_rel_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        chk("rst_rel_we2",   32'(bus.rd_we),       32'd0);
        chk("rst_no_write",  32'(wr_cnt - w0),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
